// File: rtl/ahb_vga_console_sched_if.sv
// AHB-Lite single-master bus bundle between the console scheduler and the VGA text slave.
// Signal names follow the AHB specification so existing slave wiring stays unchanged.
interface ahb_vga_console_sched_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY
    );
endinterface

// File: rtl/ahb_vga_console_sched.sv
// Two requesters share a character FIFO via round-robin arbitration; a 3-state AHB
// master drains it one non-pipelined word write per character to the VGA text register.
module ahb_vga_console_sched #(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_CHARS  = 900
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            req0_valid,
    input  logic [7:0]                      req0_data,
    output logic                            req0_ready,
    input  logic                            req1_valid,
    input  logic [7:0]                      req1_data,
    output logic                            req1_ready,
    ahb_vga_console_sched_if.master         ahb,
    output logic [9:0]                      char_count,
    output logic                            console_full,
    output logic                            busy
);

    localparam int unsigned    AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    L_DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    L_CNT1  = (AW+1)'(1);
    localparam logic [AW-1:0]  L_PTR1  = AW'(1);
    localparam logic [9:0]     L_MAX   = 10'(MAX_CHARS);
    localparam logic [1:0]     HT_IDLE   = 2'b00;
    localparam logic [1:0]     HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t        r_state;
    logic [31:0]   r_haddr;
    logic [1:0]    r_htrans;
    logic          r_hwrite;
    logic [31:0]   r_hwdata;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [9:0]    r_char_count;
    logic          r_last_grant;

    logic          w_empty;
    logic          w_fifo_full;
    logic          w_gnt1;
    logic          w_accept_ok;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_push_data;

    assign w_empty     = (r_count == '0);
    assign w_fifo_full = (r_count == L_DEPTH);

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign w_gnt1      = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept_ok = HRESETn && !w_fifo_full && !console_full;
    assign req0_ready  = req0_valid && !w_gnt1 && w_accept_ok;
    assign req1_ready  = w_gnt1 && w_accept_ok;

    assign w_push      = req0_ready || req1_ready;
    assign w_push_data = req1_ready ? req1_data : req0_data;
    assign w_pop       = (r_state == S_DATA) && ahb.HREADY;

    assign char_count   = r_char_count;
    assign console_full = (r_char_count == L_MAX);
    assign busy         = !w_empty || (r_state != S_IDLE);

    assign ahb.HADDR  = r_haddr;
    assign ahb.HTRANS = r_htrans;
    assign ahb.HWRITE = r_hwrite;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HWDATA = r_hwdata;

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_char_count <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr       <= r_wptr + L_PTR1;
                r_last_grant <= req1_ready;
                if (r_char_count != L_MAX) begin
                    r_char_count <= r_char_count + 10'd1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_PTR1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT1;
                2'b01:   r_count <= r_count - L_CNT1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_haddr  <= '0;
            r_htrans <= HT_IDLE;
            r_hwrite <= 1'b0;
            r_hwdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state  <= S_ADDR;
                        r_haddr  <= BASE_ADDR;
                        r_htrans <= HT_NONSEQ;
                        r_hwrite <= 1'b1;
                    end
                end
                S_ADDR: begin
                    // Head cannot change before the pop, so it is latched as the data word now.
                    if (ahb.HREADY) begin
                        r_state  <= S_DATA;
                        r_htrans <= HT_IDLE;
                        r_hwrite <= 1'b0;
                        r_hwdata <= {24'h0, r_mem[r_rptr]};
                    end
                end
                S_DATA: begin
                    if (ahb.HREADY) begin
                        r_state  <= S_IDLE;
                        r_haddr  <= '0;
                        r_hwdata <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_htrans <= HT_IDLE;
                    r_hwrite <= 1'b0;
                    r_hwdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_vga_console_sched.md
AHB_VGA_CONSOLE_SCHED -- requirements
Module: ahb_vga_console_sched

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h5000_0000, meaning the AHB address of the VGA console text register.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the character FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter MAX_CHARS, default 900, meaning the console capacity (30 columns x 30 rows).
REQ-004 HCLK, input, 1: sole clock, rising edge.
REQ-005 HRESETn, input, 1: reset, asynchronous assert, active-low.
REQ-006 req0_valid, input, 1: requester 0 has a character.
REQ-007 req0_data, input, 8: requester 0 character code.
REQ-008 req0_ready, output, 1: requester 0 character accepted this cycle.
REQ-009 req1_valid, input, 1: requester 1 has a character.
REQ-010 req1_data, input, 8: requester 1 character code.
REQ-011 req1_ready, output, 1: requester 1 character accepted this cycle.
REQ-012 HADDR, output, 32: AHB master address.
REQ-013 HTRANS, output, 2: AHB transfer type; only IDLE (2'b00) or NONSEQ (2'b10) is driven.
REQ-014 HWRITE, output, 1: AHB write strobe.
REQ-015 HSIZE, output, 3: AHB transfer size; constant 3'b010 (word).
REQ-016 HWDATA, output, 32: AHB write data.
REQ-017 HREADY, input, 1: AHB bus ready (slave HREADYOUT).
REQ-018 char_count, output, 10: number of characters accepted since reset.
REQ-019 console_full, output, 1: char_count has reached MAX_CHARS.
REQ-020 busy, output, 1: FIFO is non-empty or an AHB transfer is in progress.

Function
REQ-021 Arbitration SHALL be round-robin with a 1-bit last_grant register.
- Only one valid: grant that requester.
- Both valid: grant the requester that is not last_grant.
REQ-022 reqN_ready SHALL be high only when requester N is granted, the FIFO is not full, and console_full is low; at most one ready SHALL be high per cycle.
REQ-023 On a handshake (valid && ready):
- The character SHALL be written into the FIFO.
- char_count SHALL increment by 1.
- last_grant SHALL be set to N.
REQ-024 A push and a pop in the same cycle SHALL both take effect.
- FIFO occupancy SHALL be unchanged.
- When the FIFO was full at that edge, ready SHALL still be low that cycle (ready is based on the registered full flag).
REQ-025 char_count SHALL saturate at MAX_CHARS, and SHALL never wrap.
REQ-026 console_full SHALL be high exactly when char_count == MAX_CHARS; all ready signals SHALL then stay low until reset.
REQ-027 The master FSM SHALL have states IDLE, ADDR and DATA.
REQ-028 IDLE:
- Drive HTRANS = IDLE and HWRITE = 0.
- When the FIFO is non-empty, go to ADDR on the next edge.
REQ-029 ADDR:
- Drive HTRANS = NONSEQ, HADDR = BASE_ADDR, HWRITE = 1, HSIZE = word.
- Hold all of these until HREADY is sampled high.
- Then go to DATA.
REQ-030 DATA:
- Drive HTRANS = IDLE and HWDATA = {24'h0, FIFO head}.
- Hold HWDATA until HREADY is sampled high.
- Then pop the FIFO and go to IDLE.
REQ-031 Transfers SHALL NOT be pipelined, so each character costs at least 3 cycles. The minimum FIFO-non-empty-to-address-phase latency SHALL be 1 cycle.
REQ-032 Characters SHALL be written to the bus in exact acceptance order, with no loss or duplication.
REQ-033 HWDATA SHALL be 32'h0 outside the DATA state.
REQ-034 busy SHALL be high when the FIFO is non-empty or the FSM state is not IDLE.

Reset
REQ-035 While HRESETn is low, outputs SHALL take their reset values asynchronously:
- FSM = IDLE, HTRANS = 2'b00, HWRITE = 0, HADDR = 0, HWDATA = 0.
- FIFO empty, char_count = 0, console_full = 0, busy = 0.
- last_grant = 1, so requester 0 wins the first tie.
- req0_ready = req1_ready = 0.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer and discard the FIFO contents. No bus activity SHALL occur until the first edge after deassertion.

Verification
REQ-037 The bench SHALL cover these scenarios:
- Single char: req0 sends 8'h41 with HREADY=1 -> NONSEQ to BASE_ADDR 1 cycle later; HWDATA=32'h41 the next cycle; char_count=1.
- Tie: both requesters valid continuously with chars 'A' and 'B' -> bus order is A,B,A,B; each handshake alternates.
- Wait states: HREADY low for 3 cycles during ADDR and again during DATA -> HADDR/HTRANS and HWDATA held stable; no pop until HREADY high.
- FIFO full: HREADY held low, req0 pushes 9 chars -> ready low after 8 accepted; accepted count resumes when the bus drains; no loss.
- Capacity: 900 chars pushed -> console_full=1, ready stays low, char_count=900; queued chars still drain to the bus.
- Reset mid-DATA: HRESETn pulsed low -> HTRANS=IDLE and busy=0 immediately; the next char after reset is the first on the bus.
